// File: rtl/uart_rx_if.sv
// Serial input and received-byte outputs of the UART receiver.
// slave is the receiver side; master is the line driver / byte consumer.
interface uart_rx_if;
    logic       rx_i;
    logic [7:0] data_o;
    logic       rx_done;
    logic       frame_err;

    modport master (output rx_i, input data_o, input rx_done, input frame_err);
    modport slave  (input rx_i, output data_o, output rx_done, output frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle rx_done / frame_err pulses.
// rst_n is active high despite its name.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  rx_if
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic [1:0]       sync_q;
    logic             rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_if.rx_i};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shift_q         <= '0;
            rx_if.data_o    <= 8'h00;
            rx_if.rx_done   <= 1'b0;
            rx_if.frame_err <= 1'b0;
        end else begin
            rx_if.rx_done   <= 1'b0;
            rx_if.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                // Half a bit in: a start bit that is already gone was a glitch.
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt              <= '0;
                        shift_q[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_if.data_o  <= shift_q;
                            rx_if.rx_done <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            rx_if.frame_err <= 1'b1;
                            state           <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // A held-low line must return high before a new frame is hunted.
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic clk;
    logic rst_n;

    uart_rx_if u_if();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sb_q[$];
    int         checks;
    int         errors;
    int         done_cnt;
    int         ferr_cnt;
    logic [7:0] prev_data;

    // Monitor: pops expected bytes on rx_done, tracks pulses and data_o stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (u_if.rx_done) begin
                done_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rx_done: got data_o=%02h, expected no pulse", u_if.data_o);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb_q.pop_front();
                    if (u_if.data_o !== exp_b) begin
                        errors++;
                        $display("FAIL sb_data: got %02h, expected %02h", u_if.data_o, exp_b);
                    end
                end
            end
            if (u_if.frame_err) ferr_cnt++;
            checks++;
            if (u_if.rx_done && u_if.frame_err) begin
                errors++;
                $display("FAIL pulse_overlap: got rx_done=1 frame_err=1, expected not both");
            end
            checks++;
            if (u_if.data_o !== prev_data && !u_if.rx_done) begin
                errors++;
                $display("FAIL data_hold: got %02h, expected %02h (no rx_done)", u_if.data_o, prev_data);
            end
        end
        prev_data = u_if.data_o;
    end

    task automatic bit_time(input logic v);
        u_if.rx_i = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_bit);
        u_if.rx_i = 1'b1;
    endtask

    // Bounded wait for the scoreboard to drain, then a short settle.
    task automatic wait_sb(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40 * CPB) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending bytes, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        u_if.rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (u_if.data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", u_if.data_o); end
        checks++;
        if (u_if.rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b, expected 0", u_if.rx_done); end
        checks++;
        if (u_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", u_if.frame_err); end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        sb_q.push_back(8'h01);
        send_byte(8'h01, 1'b1);
        wait_sb("single");
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d, expected 1", done_cnt - d0); end
        checks++;
        if (u_if.data_o !== 8'h01) begin errors++; $display("FAIL single_data: got %02h, expected 01", u_if.data_o); end
        checks++;
        if (ferr_cnt != f0) begin errors++; $display("FAIL single_ferr: got %0d, expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        sb_q.push_back(8'hA5);
        sb_q.push_back(8'h3C);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        wait_sb("b2b");
        checks++;
        if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt - d0); end
        checks++;
        if (u_if.data_o !== 8'h3C) begin errors++; $display("FAIL b2b_data: got %02h, expected 3c", u_if.data_o); end
    endtask

    task automatic test_glitch();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        u_if.rx_i = 1'b0;
        repeat (4) @(posedge clk);
        u_if.rx_i = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL glitch_done: got %0d, expected 0", done_cnt - d0); end
        checks++;
        if (ferr_cnt != f0) begin errors++; $display("FAIL glitch_ferr: got %0d, expected 0", ferr_cnt - f0); end
        checks++;
        if (dut.state !== 3'd0) begin errors++; $display("FAIL glitch_state: got %0d, expected 0 (IDLE)", dut.state); end
    endtask

    task automatic test_frame_err();
        int d0, f0;
        sb_q.push_back(8'h77);
        send_byte(8'h77, 1'b1);
        wait_sb("ferr_pre");
        d0 = done_cnt; f0 = ferr_cnt;
        send_byte(8'h55, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        checks++;
        if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d, expected 1", ferr_cnt - f0); end
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL ferr_done: got %0d, expected 0", done_cnt - d0); end
        checks++;
        if (u_if.data_o !== 8'h77) begin errors++; $display("FAIL ferr_data: got %02h, expected 77", u_if.data_o); end
    endtask

    task automatic test_break();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        u_if.rx_i = 1'b0;
        repeat (40 * CPB) @(posedge clk);
        u_if.rx_i = 1'b1;
        repeat (CPB) @(posedge clk);
        sb_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1);
        wait_sb("break");
        checks++;
        if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL break_ferr: got %0d, expected 1", ferr_cnt - f0); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL break_done: got %0d, expected 1", done_cnt - d0); end
        checks++;
        if (u_if.data_o !== 8'hC3) begin errors++; $display("FAIL break_data: got %02h, expected c3", u_if.data_o); end
    endtask

    task automatic test_reset_midframe();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        u_if.rx_i = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        rst_n     = 1'b1;
        u_if.rx_i = 1'b1;
        #1;
        checks++;
        if (u_if.data_o !== 8'h00) begin errors++; $display("FAIL midrst_data_async: got %02h, expected 00", u_if.data_o); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (12 * CPB) @(posedge clk);
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL midrst_done: got %0d, expected 0", done_cnt - d0); end
        checks++;
        if (ferr_cnt != f0) begin errors++; $display("FAIL midrst_ferr: got %0d, expected 0", ferr_cnt - f0); end
        checks++;
        if (u_if.data_o !== 8'h00) begin errors++; $display("FAIL midrst_data_hold: got %02h, expected 00", u_if.data_o); end
        sb_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        wait_sb("midrst");
        checks++;
        if (u_if.data_o !== 8'h5A) begin errors++; $display("FAIL midrst_data: got %02h, expected 5a", u_if.data_o); end
    endtask

    task automatic test_random_stream();
        int d0;
        logic [7:0] b;
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            sb_q.push_back(b);
            send_byte(b, 1'b1);
        end
        wait_sb("stream");
        checks++;
        if (done_cnt - d0 != 6) begin errors++; $display("FAIL stream_done_count: got %0d, expected 6", done_cnt - d0); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        ferr_cnt  = 0;
        prev_data = 8'h00;
        rst_n     = 1'b1;
        u_if.rx_i = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_break();
        test_reset_midframe();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
